// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: RISC-V width codes, region tags and MMIO offsets.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] DMEM_TAG = 2'b00;

  localparam logic [3:0] MMIO_OFF_CYCLE   = 4'h0;
  localparam logic [3:0] MMIO_OFF_INSTRET = 4'h4;
  localparam logic [3:0] MMIO_OFF_CLEAR   = 4'h8;

  typedef enum logic [1:0] {
    REGION_UNMAPPED = 2'd0,
    REGION_DMEM     = 2'd1,
    REGION_MMIO     = 2'd2
  } region_e;

  // Width is carried in funct3[1:0]; the sign bit does not affect alignment.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_mmio_counters.sv
// Free-running cycle and retired-instruction counters with a shared clear.
module mem_mmio_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_retire,
  input  logic        clear,
  output logic [31:0] cycle_count,
  output logic [31:0] instret_count
);

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count   <= cycle_count + 32'd1;
      instret_count <= instret_count + 32'(inst_retire);
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: DMEM lane steering, fixed one-cycle load response, MMIO counter window.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int          DMEM_AWIDTH = 14,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  input  logic                   inst_retire,
  output logic [DMEM_AWIDTH-1:0] dmem_addra,
  output logic [31:0]            dmem_dina,
  output logic [3:0]             dmem_wea,
  input  logic [31:0]            dmem_douta,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   misalign
);

  logic [1:0]  lo;
  region_e     region;
  logic        mis;
  logic        is_store;
  logic        mmio_word;
  logic        cnt_clear;
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
  logic [31:0] mmio_rdata;

  logic        pend_valid;
  logic [2:0]  pend_f3;
  logic [1:0]  pend_lo;
  region_e     pend_region;
  logic        pend_mis;
  logic [31:0] pend_mmio_data;
  logic [31:0] lane;

  assign lo         = req_addr[1:0];
  assign mis        = is_misaligned(req_funct3, lo);
  assign is_store   = req_valid && req_we && !rst;
  assign dmem_addra = req_addr[DMEM_AWIDTH+1:2];

  always_comb begin
    region = REGION_UNMAPPED;
    if (req_addr[31:30] == DMEM_TAG)
      region = REGION_DMEM;
    else if (req_addr[31:4] == MMIO_BASE[31:4])
      region = REGION_MMIO;
  end

  always_comb begin
    dmem_wea = 4'b0000;
    if (is_store && region == REGION_DMEM && !mis) begin
      case (req_funct3[1:0])
        2'b00:   dmem_wea = 4'b0001 << lo;
        2'b01:   dmem_wea = 4'b0011 << lo;
        2'b10:   dmem_wea = 4'b1111;
        default: dmem_wea = 4'b0000;
      endcase
    end
  end

  assign dmem_dina = (req_funct3[1:0] == 2'b10) ? req_wdata : (req_wdata << {lo, 3'b000});

  // Only aligned word accesses reach the counters; anything else reads as unmapped.
  assign mmio_word = (region == REGION_MMIO) && (req_funct3 == F3_W) && !mis;
  assign cnt_clear = is_store && mmio_word && (req_addr[3:0] == MMIO_OFF_CLEAR);

  always_comb begin
    case (req_addr[3:0])
      MMIO_OFF_CYCLE:   mmio_rdata = cycle_count;
      MMIO_OFF_INSTRET: mmio_rdata = instret_count;
      default:          mmio_rdata = '0;
    endcase
  end

  mem_mmio_counters u_counters (
    .clk          (clk),
    .rst          (rst),
    .inst_retire  (inst_retire),
    .clear        (cnt_clear),
    .cycle_count  (cycle_count),
    .instret_count(instret_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid     <= 1'b0;
      pend_f3        <= 3'b000;
      pend_lo        <= 2'b00;
      pend_region    <= REGION_UNMAPPED;
      pend_mis       <= 1'b0;
      pend_mmio_data <= '0;
      misalign       <= 1'b0;
    end else begin
      pend_valid     <= req_valid && !req_we;
      pend_f3        <= req_funct3;
      pend_lo        <= lo;
      pend_region    <= region;
      pend_mis       <= mis;
      pend_mmio_data <= mmio_word ? mmio_rdata : 32'd0;
      misalign       <= req_valid && mis;
    end
  end

  assign rsp_valid = pend_valid;
  assign lane      = dmem_douta >> {pend_lo, 3'b000};

  always_comb begin
    rsp_rdata = '0;
    if (pend_valid && !pend_mis) begin
      case (pend_region)
        REGION_DMEM: begin
          case (pend_f3)
            F3_B:    rsp_rdata = {{24{lane[7]}}, lane[7:0]};
            F3_H:    rsp_rdata = {{16{lane[15]}}, lane[15:0]};
            F3_W:    rsp_rdata = dmem_douta;
            F3_BU:   rsp_rdata = {24'd0, lane[7:0]};
            F3_HU:   rsp_rdata = {16'd0, lane[15:0]};
            default: rsp_rdata = '0;
          endcase
        end
        REGION_MMIO: rsp_rdata = pend_mmio_data;
        default:     rsp_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed literal cases, then random traffic against a behavioural model.
module tb_mem_access_unit;

  localparam int          AW = 14;
  localparam logic [31:0] MB = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'd0;
  logic [31:0]   req_addr = 32'd0;
  logic [31:0]   req_wdata = 32'd0;
  logic          inst_retire = 1'b0;
  logic [AW-1:0] dmem_addra;
  logic [31:0]   dmem_dina;
  logic [3:0]    dmem_wea;
  logic [31:0]   dmem_douta;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          misalign;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DMEM_AWIDTH(AW), .MMIO_BASE(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .inst_retire(inst_retire),
    .dmem_addra (dmem_addra),
    .dmem_dina  (dmem_dina),
    .dmem_wea   (dmem_wea),
    .dmem_douta (dmem_douta),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .misalign   (misalign)
  );

  // Synchronous single-port RAM standing in for the DMEM block.
  bit [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dmem_wea[i]) mem[dmem_addra][8*i +: 8] <= dmem_dina[8*i +: 8];
    dmem_douta <= mem[dmem_addra];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
    int size;
    size = int'(f3) % 4;
    if (size == 0) return 1'b0;
    return (a % (32'd1 << size)) != 0;
  endfunction

  function automatic bit m_is_dmem(input logic [31:0] a);
    return (a >> 30) == 0;
  endfunction

  function automatic bit m_is_mmio(input logic [31:0] a);
    return (a >> 4) == (MB >> 4);
  endfunction

  function automatic logic [3:0] m_wea(input bit v, input bit we, input bit r,
                                       input logic [2:0] f3, input logic [31:0] a);
    int size, nbytes;
    if (!v || !we || r || !m_is_dmem(a) || m_mis(f3, a)) return 4'd0;
    size = int'(f3) % 4;
    if (size == 2) return 4'hF;
    nbytes = 1 << size;
    return 4'(((1 << nbytes) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] word, input logic [31:0] cyc,
                                         input logic [31:0] inst);
    logic [31:0] sh;
    if (m_mis(f3, a)) return 32'd0;
    if (m_is_dmem(a)) begin
      sh = word >> (8 * (a % 4));
      case (f3)
        3'd0:    return ((sh % 256) >= 128) ? (sh % 256) + 32'hFFFF_FF00 : sh % 256;
        3'd1:    return ((sh % 65536) >= 32768) ? (sh % 65536) + 32'hFFFF_0000 : sh % 65536;
        3'd2:    return word;
        3'd4:    return sh % 256;
        3'd5:    return sh % 65536;
        default: return 32'd0;
      endcase
    end
    if (m_is_mmio(a) && f3 == 3'd2) begin
      if (a % 16 == 0) return cyc;
      if (a % 16 == 4) return inst;
    end
    return 32'd0;
  endfunction

  logic [31:0] m_cyc = 32'd0, m_inst = 32'd0;
  logic        exp_valid = 1'b0, exp_mis = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin
    logic        is_ld, clr;
    logic [AW-1:0] widx;
    is_ld = !rst && req_valid && !req_we;
    clr   = req_valid && req_we && req_funct3 == 3'd2 && m_is_mmio(req_addr) && req_addr % 16 == 8;
    widx  = req_addr[AW+1:2];
    exp_valid <= is_ld;
    exp_rdata <= is_ld ? m_load(req_funct3, req_addr, mem[widx], m_cyc, m_inst) : 32'd0;
    exp_mis   <= !rst && req_valid && m_mis(req_funct3, req_addr);
    if (rst || clr) begin
      m_cyc  <= 32'd0;
      m_inst <= 32'd0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_inst <= m_inst + (inst_retire ? 32'd1 : 32'd0);
    end
    if (rst) model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    logic [3:0] ew;
    if (model_ok) begin
      ew = m_wea(req_valid, req_we, rst, req_funct3, req_addr);
      chk("addra", {18'd0, dmem_addra}, (req_addr >> 2) % (32'd1 << AW));
      chk("wea", {28'd0, dmem_wea}, {28'd0, ew});
      if (ew != 4'd0)
        chk("dina", dmem_dina, (req_funct3 % 4 == 2) ? req_wdata : req_wdata << (8 * (req_addr % 4)));
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = v;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    int sel;
    logic [31:0] a;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Reset with a store presented: no write enables, cleared outputs.
    rst = 1'b1;
    drive(1'b1, 1'b1, 3'd2, 32'd0, 32'h1234_5678);
    step(); step();
    @(negedge clk);
    chk("rst_wea", {28'd0, dmem_wea}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    idle();
    step();
    rst = 1'b0;

    // Ten cycles after release the cycle counter reads 10.
    repeat (10) step();
    drive(1'b1, 1'b0, 3'd2, MB, 32'd0);
    step(); idle();
    @(negedge clk);
    chk("cycle_read_valid", {31'd0, rsp_valid}, 32'd1);
    chk("cycle_read", rsp_rdata, 32'd10);

    // sb to byte 3.
    step();
    drive(1'b1, 1'b1, 3'd0, 32'h0000_0003, 32'h0000_00A5);
    @(negedge clk);
    chk("sb_wea", {28'd0, dmem_wea}, 32'h8);
    chk("sb_dina", dmem_dina, 32'hA500_0000);
    chk("sb_addra", {18'd0, dmem_addra}, 32'd0);
    step();
    drive(1'b1, 1'b1, 3'd2, 32'h0000_0000, 32'h0080_0000);
    step();

    // lb then lbu at byte 2 of 0x0080_0000.
    drive(1'b1, 1'b0, 3'd0, 32'h0000_0002, 32'd0);
    step();
    drive(1'b1, 1'b0, 3'd4, 32'h0000_0002, 32'd0);
    @(negedge clk);
    chk("lb_valid", {31'd0, rsp_valid}, 32'd1);
    chk("lb_rdata", rsp_rdata, 32'hFFFF_FF80);
    step(); idle();
    @(negedge clk);
    chk("lbu_rdata", rsp_rdata, 32'h0000_0080);

    // Misaligned sw then lw at 0x6.
    step();
    drive(1'b1, 1'b1, 3'd2, 32'h0000_0006, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("mis_sw_wea", {28'd0, dmem_wea}, 32'd0);
    step();
    drive(1'b1, 1'b0, 3'd2, 32'h0000_0006, 32'd0);
    @(negedge clk);
    chk("mis_sw_flag", {31'd0, misalign}, 32'd1);
    step(); idle();
    @(negedge clk);
    chk("mis_lw_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mis_lw_rdata", rsp_rdata, 32'd0);
    chk("mis_lw_flag", {31'd0, misalign}, 32'd1);

    // Clear with a same-cycle retire, then read both counters back to back.
    step();
    drive(1'b1, 1'b1, 3'd2, MB + 32'h8, 32'hFFFF_FFFF);
    inst_retire = 1'b1;
    step();
    inst_retire = 1'b0;
    drive(1'b1, 1'b0, 3'd2, MB + 32'h4, 32'd0);
    step();
    drive(1'b1, 1'b0, 3'd2, MB, 32'd0);
    @(negedge clk);
    chk("clr_instret", rsp_rdata, 32'd0);
    step(); idle();
    @(negedge clk);
    chk("clr_cycle", rsp_rdata, 32'd1);

    // Load issued while in reset yields no response; counters restart at 0.
    step();
    drive(1'b1, 1'b0, 3'd2, MB, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load_valid", {31'd0, rsp_valid}, 32'd0);
    step();
    drive(1'b1, 1'b0, 3'd2, MB + 32'h4, 32'd0);
    @(negedge clk);
    chk("post_rst_cycle", rsp_rdata, 32'd0);
    step(); idle();
    @(negedge clk);
    chk("post_rst_instret", rsp_rdata, 32'd0);
    step();

    // Random traffic, compared every cycle against the model.
    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel <= 5)      a = $urandom_range(0, 255);
      else if (sel == 6) a = $urandom & 32'h3FFF_FFFF;
      else if (sel <= 8) a = MB + $urandom_range(0, 15);
      else               a = ($urandom_range(0, 1) == 0) ? (32'h4000_0000 | $urandom) : (MB + 32'h10 + $urandom_range(0, 255));
      req_we = ($urandom_range(0, 1) == 1);
      drive($urandom_range(0, 9) < 8, req_we,
            req_we ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)],
            a, $urandom);
      inst_retire = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end

    idle();
    rst = 1'b0;
    inst_retire = 1'b0;
    step(); step();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter DMEM_AWIDTH, default 14, the DMEM word-address width.
REQ-002 The block SHALL have parameter MMIO_BASE, default 32'h8000_0000, the base byte address of the counter region.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 req_valid  in  1  memory instruction present this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V width/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-justified.
REQ-010 inst_retire  in  1  one instruction retired this cycle.
REQ-011 dmem_addra  out  DMEM_AWIDTH  DMEM word address.
REQ-012 dmem_dina  out  32  lane-shifted store data.
REQ-013 dmem_wea  out  4  DMEM byte write enables.
REQ-014 dmem_douta  in  32  DMEM read word, valid one cycle after the address.
REQ-015 rsp_valid  out  1  load result valid.
REQ-016 rsp_rdata  out  32  aligned, extended load result.
REQ-017 misalign  out  1  pulse: the previous-cycle request was misaligned.

Function
REQ-018 Address decode SHALL be: req_addr[31:30]==2'b00 selects DMEM; req_addr[31:4]==MMIO_BASE[31:4] selects MMIO; any other address is unmapped.
REQ-019 dmem_addra SHALL equal req_addr[DMEM_AWIDTH+1:2] combinationally, whatever the request.
REQ-020 A DMEM store SHALL drive dmem_wea combinationally in the request cycle: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111.
REQ-021 dmem_dina SHALL be req_wdata shifted left by 8*addr[1:0] for sb/sh, and unshifted for sw.
REQ-022 dmem_wea SHALL be 0 when req_valid=0, on loads, on MMIO/unmapped addresses, on misaligned stores, and while rst=1.
REQ-023 Misaligned SHALL mean: half-word access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-024 A load issued in cycle N SHALL give rsp_valid=1 in cycle N+1 only, for every region, so load latency is fixed at one cycle.
REQ-025 Issue-cycle funct3, addr[1:0], region and misaligned flag SHALL be held in a one-entry pending register that is overwritten every cycle (back-to-back loads supported).
REQ-026 A DMEM load SHALL select the byte/half-word of dmem_douta given by the registered addr[1:0], then sign-extend (lb/lh) or zero-extend (lbu/lhu).
REQ-027 Misaligned and unmapped loads SHALL return rsp_rdata=0, still with rsp_valid=1.
REQ-028 misalign SHALL be 1 in cycle N+1 for any misaligned load or store in cycle N, and 0 otherwise.
REQ-029 MMIO map (word access only; other widths are treated as unmapped): +0x0 cycle counter (read-only), +0x4 instret counter (read-only), +0x8 write any value to clear both counters.
REQ-030 The cycle counter SHALL increment by 1 every cycle with rst=0, wrapping 0xFFFF_FFFF to 0.
REQ-031 The instret counter SHALL increment by 1 when inst_retire=1, wrapping the same way.
REQ-032 A clear write SHALL take priority over a same-cycle increment: both counters read 0 in the following cycle.
REQ-033 An MMIO load SHALL return the counter value sampled in the issue cycle.
REQ-034 rsp_rdata SHALL be 0 whenever rsp_valid=0.

Reset
REQ-035 With rst=1 at a clock edge, the following SHALL be 0 in the next cycle: both counters, rsp_valid, misalign, rsp_rdata, and the pending register.
REQ-036 A load issued in the same cycle that rst=1 SHALL produce no response.

Structure
REQ-037 The funct3 encodings, region decode constants and MMIO offsets SHALL live in the shared package mem_access_pkg.
REQ-038 The counters and their clear logic SHALL be the sub-module mem_mmio_counters; lane steering and extension stay in mem_access_unit.

Verification
REQ-039 sb to 0x0000_0003 with wdata 0x0000_00A5 -> dmem_wea=4'b1000, dmem_dina=0xA500_0000, dmem_addra=0.
REQ-040 lb then lbu, both at 0x0000_0002, with dmem_douta=0x0080_0000 -> rsp_rdata 0xFFFF_FF80 then 0x0000_0080, each one cycle after issue.
REQ-041 sw to 0x0000_0006 -> dmem_wea=0, misalign=1 in the next cycle; lw at the same address -> rsp_valid=1, rsp_rdata=0.
REQ-042 Release rst, wait 10 cycles, lw to 0x8000_0000 -> rsp_rdata=9 or 10 (sampled value), matching a model counter exactly.
REQ-043 Clear write to 0x8000_0008 in the same cycle as inst_retire=1 -> lw to 0x8000_0004 in the next cycle returns 0.
REQ-044 Assert rst in the cycle a lw is issued -> rsp_valid=0 in the following cycle, and both counters read 0 afterwards.
